// File: rtl/nn_ctrl_pkg.sv
// Shared control definitions for the neural-network layer sequencer:
// state encoding and a counter-width helper.
package nn_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLEAR    = 3'd1;
  localparam logic [2:0] ST_ACCUM    = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_ACTIVATE = 3'd4;
  localparam logic [2:0] ST_WRITE    = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    CLEAR    = ST_CLEAR,
    ACCUM    = ST_ACCUM,
    DRAIN    = ST_DRAIN,
    ACTIVATE = ST_ACTIVATE,
    WRITE    = ST_WRITE,
    DONE     = ST_DONE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // A counter that must hold values 0..n-1 still needs at least one bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/layer_sequencer_delay_line.sv
// Single-bit delay line of parameterised depth with synchronous flush;
// depth 0 is a combinational pass-through.
module delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = clk ^ rst ^ flush;
      assign dout = din;
    end else begin : g_shift
      logic [DEPTH-1:0] tap_p;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tap_p <= '0;
        end else if (flush) begin
          tap_p <= '0;
        end else begin
          tap_p <= DEPTH'({tap_p, din});
        end
      end

      assign dout = tap_p[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/layer_sequencer.sv
// Per-layer schedule for the shared MAC/ALU: clear, stream weights/inputs,
// drain the pipeline, activate, then hand the result downstream.
module layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int N_INPUTS     = 4,
  parameter int N_NEURONS    = 3,
  parameter int ADDR_W       = 8,
  parameter int RD_LAT       = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              forget,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              alu_rst,
  output logic              alu_en,
  output logic              act_en,
  output logic              out_valid,
  output logic [ADDR_W-1:0] neuron_idx
);

  localparam int IW = cnt_w(N_INPUTS);
  localparam int DW = cnt_w(DRAIN_CYCLES);
  localparam logic [IW-1:0]     LAST_IN     = IW'(N_INPUTS - 1);
  localparam logic [DW-1:0]     LAST_DRAIN  = DW'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_NEURON = ADDR_W'(N_NEURONS - 1);
  localparam logic [ADDR_W-1:0] N_IN_A      = ADDR_W'(N_INPUTS);

  state_t            state;
  logic [IW-1:0]     input_idx;
  logic [DW-1:0]     drain_cnt;
  logic [ADDR_W-1:0] neuron_q;
  logic              forget_ok;

  // Restarting a neuron is only meaningful once its reads have begun and
  // before the result has been offered downstream.
  assign forget_ok = forget && (state == ACCUM || state == DRAIN || state == ACTIVATE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      input_idx <= '0;
      drain_cnt <= '0;
      neuron_q  <= '0;
    end else if (forget_ok) begin
      state     <= CLEAR;
      input_idx <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            neuron_q <= '0;
          end
        end
        CLEAR: begin
          input_idx <= '0;
          state     <= ACCUM;
        end
        ACCUM: begin
          if (input_idx == LAST_IN) state <= DRAIN;
          else input_idx <= input_idx + 1'b1;
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            drain_cnt <= '0;
            state     <= ACTIVATE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ACTIVATE: state <= WRITE;
        WRITE: begin
          if (out_ready) begin
            if (neuron_q == LAST_NEURON) begin
              state <= DONE;
            end else begin
              neuron_q <= neuron_q + 1'b1;
              state    <= CLEAR;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign rd_en      = (state == ACCUM);
  assign alu_rst    = (state == CLEAR);
  assign act_en     = (state == ACTIVATE);
  assign out_valid  = (state == WRITE);
  assign neuron_idx = neuron_q;
  assign rd_addr    = rd_en ? (neuron_q * N_IN_A + ADDR_W'(input_idx)) : '0;

  // Read data returns RD_LAT cycles after rd_en; a forget must also kill
  // accumulates for reads already in flight.
  delay_line #(
    .DEPTH(RD_LAT)
  ) u_alu_en_dly (
    .clk  (clk),
    .rst  (reset),
    .flush(forget_ok),
    .din  (rd_en),
    .dout (alu_en)
  );

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: vector table on a minimal
// configuration, directed corner sequences and random traffic vs a model.
module tb_layer_sequencer;

  localparam int NI   = 4;
  localparam int NN   = 3;
  localparam int AW   = 8;
  localparam int LAT  = 1;
  localparam int DC   = 2;
  localparam int WPOS = NI + DC + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, forget, out_ready;
  logic busy, done, rd_en, alu_rst, alu_en, act_en, out_valid;
  logic [AW-1:0] rd_addr, neuron_idx;

  logic reset_b, start_b, forget_b, ready_b;
  logic busy_b, done_b, rd_en_b, alu_rst_b, alu_en_b, act_en_b, out_valid_b;
  logic [AW-1:0] rd_addr_b, neuron_idx_b;

  layer_sequencer #(
    .N_INPUTS(NI), .N_NEURONS(NN), .ADDR_W(AW), .RD_LAT(LAT), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .forget(forget), .out_ready(out_ready),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .alu_rst(alu_rst),
    .alu_en(alu_en), .act_en(act_en), .out_valid(out_valid), .neuron_idx(neuron_idx)
  );

  layer_sequencer #(
    .N_INPUTS(1), .N_NEURONS(1), .ADDR_W(AW), .RD_LAT(0), .DRAIN_CYCLES(1)
  ) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .forget(forget_b), .out_ready(ready_b),
    .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .alu_rst(alu_rst_b),
    .alu_en(alu_en_b), .act_en(act_en_b), .out_valid(out_valid_b), .neuron_idx(neuron_idx_b)
  );

  int checks = 0;
  int failures = 0;
  int tick_no = 0;

  // Reference model: one position counter per neuron (0 = clear,
  // 1..NI = reads, then drain, activate, write) plus a queue of past reads.
  int m_mode;  // 0 idle, 1 running, 2 done cycle
  int m_n, m_k;
  bit m_dl[$];

  // Per-run observations.
  logic [22:0] trace[0:63];
  int addrq[$];
  int act_cnt, ov_cnt, ov_n1, done_cnt, done_cyc;

  typedef struct {
    bit          st;
    bit          rdy;
    logic [6:0]  exp;  // busy,done,rd_en,alu_rst,alu_en,act_en,out_valid
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_rd_en();
    return (m_mode == 1) && (m_k >= 1) && (m_k <= NI);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_k = 0;
    m_dl.delete();
    for (int i = 0; i < LAT; i++) m_dl.push_back(1'b0);
  endtask

  task automatic model_step();
    bit flush;
    bit rdn;
    flush = 1'b0;
    rdn = m_rd_en();
    case (m_mode)
      0: if (start) begin m_mode = 1; m_n = 0; m_k = 0; end
      1: begin
        if (forget && m_k >= 1 && m_k <= NI + DC + 1) begin
          m_k = 0; flush = 1'b1;
        end else if (m_k == WPOS) begin
          if (out_ready) begin
            if (m_n == NN - 1) m_mode = 2;
            else begin m_n++; m_k = 0; end
          end
        end else begin
          m_k++;
        end
      end
      default: m_mode = 0;
    endcase
    if (flush) begin
      foreach (m_dl[i]) m_dl[i] = 1'b0;
    end else begin
      m_dl.push_back(rdn);
      void'(m_dl.pop_front());
    end
  endtask

  function automatic logic [22:0] model_vec();
    logic run, rdn;
    logic [7:0] addr, nidx;
    run  = (m_mode == 1);
    rdn  = m_rd_en();
    addr = rdn ? 8'(m_n * NI + m_k - 1) : 8'h0;
    nidx = (m_mode != 0) ? 8'(m_n) : 8'h0;
    return {(m_mode != 0), (m_mode == 2), rdn, (run && m_k == 0), m_dl[0],
            (run && m_k == NI + DC + 1), (run && m_k == WPOS), addr, nidx};
  endfunction

  function automatic logic [22:0] raw_vec();
    return {busy, done, rd_en, alu_rst, alu_en, act_en, out_valid, rd_addr, neuron_idx};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {busy, done, rd_en, alu_rst, alu_en, act_en, out_valid,
            rd_en ? rd_addr : 8'h0, busy ? neuron_idx : 8'h0};
  endfunction

  task automatic tick();
    if (!reset) model_step();
    @(posedge clk);
    @(negedge clk);
    tick_no++;
    chk($sformatf("model_cmp_t%0d", tick_no), 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; forget = 1'b0; out_ready = 1'b1;
    model_reset();
    #1 chk("reset_outputs", 32'(raw_vec()), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("first_idle_outputs", 32'(raw_vec()), 32'h0);
  endtask

  // Drive n cycles; s0..s2 are start cycles, f_at the forget cycle,
  // r_lo..r_hi the cycles with out_ready low (-1 disables).
  task automatic run(input int n, input int s0, input int s1, input int s2,
                     input int f_at, input int r_lo, input int r_hi);
    addrq.delete();
    act_cnt = 0; ov_cnt = 0; ov_n1 = 0; done_cnt = 0; done_cyc = -1;
    trace[0] = raw_vec();
    for (int c = 0; c < n; c++) begin
      start     = (c == s0) || (c == s1) || (c == s2);
      forget    = (c == f_at);
      out_ready = !(c >= r_lo && c <= r_hi);
      tick();
      trace[c + 1] = raw_vec();
      if (rd_en) addrq.push_back(int'(rd_addr));
      if (act_en) act_cnt++;
      if (out_valid) ov_cnt++;
      if (out_valid && neuron_idx == 8'd1) ov_n1++;
      if (done) begin done_cnt++; done_cyc = c + 1; end
    end
    start = 1'b0; forget = 1'b0; out_ready = 1'b1;
  endtask

  task automatic check_addrs(input string name, input int exp_q[$]);
    chk({name, "_count"}, 32'(addrq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < addrq.size(); i++)
      chk($sformatf("%s_%0d", name, i), 32'(addrq[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int exp_q[$];
    logic [6:0] ob;

    reset = 1'b1; start = 1'b0; forget = 1'b0; out_ready = 1'b1;
    reset_b = 1'b1; start_b = 1'b0; forget_b = 1'b0; ready_b = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(raw_vec()), 32'h0);
    reset = 1'b0; reset_b = 1'b0;
    chk("reset_state_b", 32'({busy_b, done_b, rd_en_b, alu_rst_b, alu_en_b, act_en_b,
                              out_valid_b, rd_addr_b, neuron_idx_b}), 32'h0);

    // Minimal configuration: single read, alu_en coincident with rd_en.
    tbl[0]  = '{1'b1, 1'b1, 7'b0000000};
    tbl[1]  = '{1'b0, 1'b1, 7'b1001000};
    tbl[2]  = '{1'b0, 1'b1, 7'b1010100};
    tbl[3]  = '{1'b0, 1'b1, 7'b1000000};
    tbl[4]  = '{1'b0, 1'b1, 7'b1000010};
    tbl[5]  = '{1'b0, 1'b1, 7'b1000001};
    tbl[6]  = '{1'b1, 1'b1, 7'b1100000};
    tbl[7]  = '{1'b0, 1'b1, 7'b0000000};
    tbl[8]  = '{1'b1, 1'b1, 7'b0000000};
    tbl[9]  = '{1'b0, 1'b1, 7'b1001000};
    tbl[10] = '{1'b0, 1'b1, 7'b1010100};
    tbl[11] = '{1'b0, 1'b1, 7'b1000000};
    tbl[12] = '{1'b0, 1'b1, 7'b1000010};
    tbl[13] = '{1'b0, 1'b0, 7'b1000001};
    tbl[14] = '{1'b0, 1'b0, 7'b1000001};
    tbl[15] = '{1'b0, 1'b1, 7'b1000001};
    tbl[16] = '{1'b0, 1'b1, 7'b1100000};
    tbl[17] = '{1'b0, 1'b1, 7'b0000000};
    for (int i = 0; i < 18; i++) begin
      start_b = tbl[i].st;
      ready_b = tbl[i].rdy;
      ob = {busy_b, done_b, rd_en_b, alu_rst_b, alu_en_b, act_en_b, out_valid_b};
      chk($sformatf("tbl_b_%0d", i), 32'({ob, rd_addr_b, neuron_idx_b}), 32'({tbl[i].exp, 16'h0}));
      @(posedge clk);
      @(negedge clk);
    end
    start_b = 1'b0;

    // Plain layer with out_ready high.
    apply_reset();
    run(32, 0, -1, -1, -1, -1, -2);
    exp_q.delete();
    for (int i = 0; i < NI * NN; i++) exp_q.push_back(i);
    check_addrs("plain_addr", exp_q);
    chk("plain_act_cnt", 32'(act_cnt), 32'd3);
    chk("plain_ov_cnt", 32'(ov_cnt), 32'd3);
    chk("plain_done_cyc", 32'(done_cyc), 32'd28);
    chk("plain_done_cnt", 32'(done_cnt), 32'd1);
    chk("plain_busy_at_done", 32'(trace[28][22]), 32'd1);
    chk("plain_busy_after_done", 32'(trace[29][22]), 32'd0);

    // Back-pressure in neuron 1's WRITE.
    apply_reset();
    run(38, 0, -1, -1, -1, 18, 22);
    chk("bp_done_cyc", 32'(done_cyc), 32'd33);
    chk("bp_ov_n1_cycles", 32'(ov_n1), 32'd6);
    chk("bp_nidx_held", 32'(trace[22][7:0]), 32'd1);

    // Forget at input_idx 2 of neuron 1.
    apply_reset();
    run(36, 0, -1, -1, 13, -1, -2);
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(i);
    for (int i = 4; i < 12; i++) exp_q.push_back(i);
    check_addrs("fg_addr", exp_q);
    chk("fg_alu_rst", 32'(trace[14][19]), 32'd1);
    chk("fg_alu_en_flushed", 32'(trace[14][18]), 32'd0);
    chk("fg_nidx", 32'(trace[14][7:0]), 32'd1);
    chk("fg_done_cyc", 32'(done_cyc), 32'd32);

    // Stray start pulses during ACCUM and in the DONE cycle.
    apply_reset();
    run(36, 0, 3, 28, -1, -1, -2);
    chk("st_done_cnt", 32'(done_cnt), 32'd1);
    chk("st_done_cyc", 32'(done_cyc), 32'd28);
    chk("st_idle_after", 32'(trace[30][22]), 32'd0);

    // Asynchronous reset in the first DRAIN cycle.
    apply_reset();
    run(6, 0, -1, -1, -1, -1, -2);
    chk("ar_in_drain", 32'({trace[6][22], trace[6][20]}), 32'b10);
    #2 reset = 1'b1;
    model_reset();
    #1 chk("ar_outputs_zero", 32'(raw_vec()), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("ar_first_idle", 32'(raw_vec()), 32'h0);
    run(30, -1, -1, -1, -1, -1, -2);
    chk("ar_no_done", 32'(done_cnt), 32'd0);

    // Random traffic against the model.
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 9) < 2);
      forget    = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    start = 1'b0; forget = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
